uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Upstream stage of the native-to-AXI-lite bridge in the UART register-access path.
- Consumes the UART RX byte stream and parses binary read/write commands.
- Issues single native wr/rd requests to the bridge, then serialises a status byte, plus read data when applicable, onto the UART TX byte stream.

Parameters:
- W, 32, native data width in bits; multiple of 8; NB = W/8 data bytes per transfer.
- A, 4, native address width; 1..7.
- TIMEOUT, 100000, clk cycles allowed between RX bytes of one command, and for the native completion wait.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- rx_valid_i  in  1  one-cycle strobe, RX byte available.
- rx_data_i  in  8  RX byte.
- tx_valid_o  out  1  TX byte valid.
- tx_data_o  out  8  TX byte.
- tx_ready_i  in  1  TX accepts the byte when valid&ready.
- wr_valid_o  out  1  one-cycle write request.
- wr_addr_o  out  A  write address.
- wr_data_o  out  W  write data.
- wr_ready_i  in  1  bridge idle / write complete.
- wr_err_i  in  1  bridge write error, sampled at completion.
- rd_valid_o  out  1  one-cycle read request.
- rd_addr_o  out  A  read address.
- rd_ready_i  in  1  read data valid / read complete.
- rd_data_i  in  W  read data.
- rd_err_i  in  1  read error, sampled at completion.
- ovf_o  out  1  sticky: an RX byte was dropped while busy.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Command byte format:
  - bit7 = 1 write, 0 read.
  - bits[A-1:0] = address.
  - bits[6:A] must be 0.
- Write command = cmd byte + NB data bytes, MSB first. Read command = cmd byte only.
- IDLE:
  - On rx_valid_i, latch the command.
  - Reserved bits nonzero -> status 0xE1, go to TX_STATUS; no native request.
  - Write -> RX_DATA, byte counter = 0.
  - Read -> ISSUE.
- RX_DATA:
  - Each rx_valid_i shifts the byte into the data register (MSB first).
  - After NB bytes -> ISSUE.
  - Timeout counter clears on every byte. If it reaches TIMEOUT -> status 0xE2, TX_STATUS; partial data is discarded.
- ISSUE:
  - Wait for wr_ready_i=1 (write) or unconditionally (read).
  - Pulse wr_valid_o or rd_valid_o for exactly one cycle, with address/data stable from that cycle onward.
  - -> WAIT.
- WAIT:
  - Sampling starts the cycle after the pulse.
  - Write completes on wr_ready_i=1; read completes on rd_ready_i=1.
  - On completion: latch rd_data_i; status = 0xEE if the err input is set, else 0x00.
  - TIMEOUT cycles without completion -> status 0xE3.
  - -> TX_STATUS.
- TX_STATUS:
  - Present status with tx_valid_o=1; hold tx_valid_o/tx_data_o stable until tx_ready_i.
  - On handshake: a read with status 0x00 -> TX_DATA; otherwise -> IDLE.
- TX_DATA:
  - Send NB bytes of the latched read data, MSB first; same hold rule as TX_STATUS.
  - After the last byte -> IDLE.
- Busy handling: rx_valid_i outside IDLE/RX_DATA drops the byte and sets ovf_o; ovf_o clears only on reset.
- Response latency: first TX byte is valid 1 cycle after completion is sampled.
- Reset mid-operation: immediate return to IDLE; no pulse is emitted after reset deassertion.
- Counters: timeout counter width = $clog2(TIMEOUT+1); saturates, never wraps.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum;
  - status constants ST_OK=0x00, ST_BADCMD=0xE1, ST_RXTO=0xE2, ST_BUSTO=0xE3, ST_BUSERR=0xEE;
  - command bit positions.
- The decoder is a single module; no sub-module is needed.

Test Plan:
- Write: RX 0x83,0xDE,0xAD,0xBE,0xEF -> one wr_valid_o pulse with addr 3, data 0xDEADBEEF; after completion TX 0x00.
- Read: RX 0x05; bridge returns 0x12345678, no error -> rd_valid_o pulse with addr 5; TX 0x00,0x12,0x34,0x56,0x78, each byte stable while tx_ready_i is held low for 3 cycles.
- Bad command (A=4): RX 0x20 -> no native pulse; TX 0xE1.
- RX timeout: RX 0x81,0x11, then TIMEOUT idle cycles -> TX 0xE2, no wr pulse; a following RX 0x02 performs a normal read.
- Bus error and busy: write with wr_err_i=1 at completion -> TX 0xEE; an RX byte during WAIT -> ovf_o=1 and the byte is ignored.
- Reset during WAIT: assert rst_n_i low asynchronously -> all outputs 0 immediately; after release, no stray TX byte and no stray wr/rd pulse.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder: FSM states, status codes
// and command byte layout.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRxData,
    StIssue,
    StWait,
    StTxStatus,
    StTxData
  } state_e;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCMD = 8'hE1;
  localparam logic [7:0] ST_RXTO   = 8'hE2;
  localparam logic [7:0] ST_BUSTO  = 8'hE3;
  localparam logic [7:0] ST_BUSERR = 8'hEE;

  localparam int unsigned CMD_WR_BIT  = 7;
  localparam int unsigned CMD_RSV_MSB = 6;

  // Bits [CMD_RSV_MSB:addr_w] of a command byte must be zero.
  function automatic logic [7:0] rsv_mask(int unsigned addr_w);
    logic [7:0] m;
    m = '0;
    for (int unsigned i = 0; i <= CMD_RSV_MSB; i++) begin
      if (i >= addr_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Parses binary read/write commands from a UART RX byte stream, issues one native request
// and returns a status byte (plus read data) on the UART TX byte stream.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned A       = 4,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         tx_valid_o,
  output logic [7:0]   tx_data_o,
  input  logic         tx_ready_i,
  output logic         wr_valid_o,
  output logic [A-1:0] wr_addr_o,
  output logic [W-1:0] wr_data_o,
  input  logic         wr_ready_i,
  input  logic         wr_err_i,
  output logic         rd_valid_o,
  output logic [A-1:0] rd_addr_o,
  input  logic         rd_ready_i,
  input  logic [W-1:0] rd_data_i,
  input  logic         rd_err_i,
  output logic         ovf_o
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [TW-1:0] ToMax    = TW'(TIMEOUT);
  localparam logic [CW-1:0] LastByte = CW'(NB - 1);
  localparam logic [7:0]    RsvMask  = rsv_mask(A);

  state_e         state_q, state_d;
  logic           wr_q, wr_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [W-1:0]   data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  to_q, to_d;
  logic [7:0]     status_q, status_d;
  logic           ovf_q, ovf_d;
  logic           done, err;
  logic [W-1:0]   tx_shift;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      status_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
    end
  end

  assign done = wr_q ? wr_ready_i : rd_ready_i;
  assign err  = wr_q ? wr_err_i : rd_err_i;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    status_d = status_q;
    ovf_d    = ovf_q;

    // Bytes arriving while a command is in flight are dropped.
    if (rx_valid_i && !(state_q inside {StIdle, StRxData})) ovf_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          wr_d   = rx_data_i[CMD_WR_BIT];
          addr_d = rx_data_i[A-1:0];
          if ((rx_data_i & RsvMask) != 8'h00) begin
            status_d = ST_BADCMD;
            state_d  = StTxStatus;
          end else if (rx_data_i[CMD_WR_BIT]) begin
            data_d  = '0;
            cnt_d   = '0;
            to_d    = '0;
            state_d = StRxData;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StRxData: begin
        if (rx_valid_i) begin
          data_d = (data_q << 8) | W'(rx_data_i);
          to_d   = '0;
          if (cnt_q == LastByte) state_d = StIssue;
          else                   cnt_d   = cnt_q + CW'(1);
        end else if (to_q == ToMax) begin
          data_d   = '0;
          status_d = ST_RXTO;
          state_d  = StTxStatus;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      StIssue: begin
        if (!wr_q || wr_ready_i) begin
          to_d    = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (done) begin
          if (!wr_q) data_d = rd_data_i;
          status_d = err ? ST_BUSERR : ST_OK;
          state_d  = StTxStatus;
        end else if (to_q == ToMax) begin
          status_d = ST_BUSTO;
          state_d  = StTxStatus;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      StTxStatus: begin
        if (tx_ready_i) begin
          if (!wr_q && status_q == ST_OK) begin
            cnt_d   = '0;
            state_d = StTxData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StTxData: begin
        if (tx_ready_i) begin
          if (cnt_q == LastByte) state_d = StIdle;
          else                   cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_shift   = data_q >> (8 * (NB - 1 - 32'(cnt_q)));
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state_q)
      StTxStatus: begin
        tx_valid_o = 1'b1;
        tx_data_o  = status_q;
      end
      StTxData: begin
        tx_valid_o = 1'b1;
        tx_data_o  = tx_shift[7:0];
      end
      default: ;
    endcase
    wr_valid_o = (state_q == StIssue) && wr_q && wr_ready_i;
    rd_valid_o = (state_q == StIssue) && !wr_q;
    wr_addr_o  = addr_q;
    rd_addr_o  = addr_q;
    wr_data_o  = data_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected TX bytes and native
// requests; independent monitors pop and compare when the DUT presents them.
module tb_uart_cmd_decoder;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        wr_err = 1'b0;
  logic        rd_valid;
  logic [3:0]  rd_addr;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_err = 1'b0;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_tx[$];
  req_t       exp_req[$];

  int          tx_stall = 0;
  int          br_lat = 2;
  logic        br_err = 1'b0;
  logic [31:0] br_rdata = '0;

  uart_cmd_decoder #(.W(32), .A(4), .TIMEOUT(20)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_ready_i (wr_ready),
    .wr_err_i   (wr_err),
    .rd_valid_o (rd_valid),
    .rd_addr_o  (rd_addr),
    .rd_ready_i (rd_ready),
    .rd_data_i  (rd_data),
    .rd_err_i   (rd_err),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_req.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_tx.size() != 0 || exp_req.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d tx / %0d req outstanding, expected 0 / 0",
               name, exp_tx.size(), exp_req.size());
    end
    exp_tx.delete();
    exp_req.delete();
    repeat (5) @(negedge clk);
  endtask

  // TX sink and monitor: stalls tx_ready for tx_stall cycles per byte and checks hold.
  initial begin
    int         wcnt;
    bit         held;
    logic [7:0] held_data;
    wcnt = 0;
    held = 0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready = 1'b0;
        wcnt = 0;
        held = 0;
      end else begin
        if (held) begin
          check("tx_hold_valid", 32'(tx_valid), 32'd1);
          check("tx_hold_data", 32'(tx_data), 32'(held_data));
        end
        held = 0;
        if (tx_valid) begin
          if (wcnt < tx_stall) begin
            tx_ready = 1'b0;
            wcnt++;
            held = 1;
            held_data = tx_data;
          end else begin
            tx_ready = 1'b1;
            wcnt = 0;
            if (exp_tx.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
            end else begin
              check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
          end
        end else begin
          tx_ready = 1'b0;
        end
      end
    end
  end

  // Native request monitor.
  initial begin
    req_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (wr_valid || rd_valid)) begin
        if (wr_valid && rd_valid) check("req_both", 32'd1, 32'd0);
        if (exp_req.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got wr=%b rd=%b, expected no request", wr_valid, rd_valid);
        end else begin
          r = exp_req.pop_front();
          check("req_is_wr", 32'(wr_valid), 32'(r.wr));
          if (r.wr) begin
            check("wr_addr", 32'(wr_addr), 32'(r.addr));
            check("wr_data", wr_data, r.data);
          end else begin
            check("rd_addr", 32'(rd_addr), 32'(r.addr));
          end
        end
      end
    end
  end

  // Bridge model: completes each request br_lat cycles after the pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && wr_valid) begin
        @(posedge clk);
        #1 wr_ready = 1'b0;
        repeat (br_lat) @(posedge clk);
        #1 wr_ready = 1'b1;
        wr_err = br_err;
        @(posedge clk);
        #1 wr_err = 1'b0;
      end else if (rst_n && rd_valid) begin
        @(posedge clk);
        repeat (br_lat) @(posedge clk);
        #1 rd_ready = 1'b1;
        rd_data = br_rdata;
        rd_err  = br_err;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        rd_data = '0;
        rd_err  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, no error.
    br_lat = 2; br_err = 1'b0;
    exp_req.push_back('{wr: 1'b1, addr: 4'h3, data: 32'hDEADBEEF});
    exp_tx.push_back(8'h00);
    send_byte(8'h83); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    drain("write");

    // Read with TX back-pressure.
    tx_stall = 3; br_rdata = 32'h12345678;
    exp_req.push_back('{wr: 1'b0, addr: 4'h5, data: 32'h0});
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_byte(8'h05);
    drain("read");
    tx_stall = 0;

    // Reserved bit set.
    exp_tx.push_back(8'hE1);
    send_byte(8'h20);
    drain("badcmd");

    // RX timeout, then a normal read.
    exp_tx.push_back(8'hE2);
    send_byte(8'h81); send_byte(8'h11);
    drain("rxto");
    br_lat = 1; br_rdata = 32'hA5A50F0F;
    exp_req.push_back('{wr: 1'b0, addr: 4'h2, data: 32'h0});
    exp_tx.push_back(8'h00); exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h0F); exp_tx.push_back(8'h0F);
    send_byte(8'h02);
    drain("read_after_rxto");
    check("ovf_clear", 32'(ovf), 32'd0);

    // Bus error on write, with a byte dropped during WAIT.
    br_lat = 6; br_err = 1'b1;
    exp_req.push_back('{wr: 1'b1, addr: 4'h1, data: 32'hCAFEF00D});
    exp_tx.push_back(8'hEE);
    send_byte(8'h81); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h55);
    drain("buserr");
    repeat (30) @(negedge clk);
    check("ovf_set", 32'(ovf), 32'd1);
    br_err = 1'b0;

    // Bus timeout on write.
    br_lat = 40;
    exp_req.push_back('{wr: 1'b1, addr: 4'h4, data: 32'h01020304});
    exp_tx.push_back(8'hE3);
    send_byte(8'h84); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    drain("busto");
    repeat (40) @(negedge clk);

    // Asynchronous reset during WAIT.
    br_lat = 50;
    exp_req.push_back('{wr: 1'b0, addr: 4'h3, data: 32'h0});
    send_byte(8'h03);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
